// File: rtl/pipelined_adder_sub_pkg.sv
// pipelined_adder_sub_pkg: shared helpers for the pipelined adder/subtractor
// Contents: seg_count(width, seg) returns the number of pipeline stages.
package pipelined_adder_sub_pkg;

   function automatic int unsigned seg_count(input int unsigned width, input int unsigned seg);
      return width / seg;
   endfunction

endpackage

// File: rtl/pipelined_adder_sub_segment.sv
// adder_segment: combinational SEG-bit ripple adder slice
// Ports: a, b     - SEG-bit operand slices
//        cin      - carry into the slice LSB
//        sum      - SEG-bit result slice
//        cout     - carry out of the slice MSB
//        c_msb_in - carry into the slice MSB (used for signed overflow)
module adder_segment #(
   parameter int unsigned SEG = 4
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           cin,
   output logic [SEG-1:0] sum,
   output logic           cout,
   output logic           c_msb_in
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);
   // The MSB sum bit is a^b^carry_in, so the carry into it can be recovered.
   assign c_msb_in = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipelined_adder_sub.sv
// pipelined_adder_sub: pipelined two's-complement adder/subtractor, SEG bits per stage
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready   - operand handshake (a, b, carry_in, sub)
//        out_valid/out_ready - result handshake (sum, carry_out, overflow)
//        sub=1 computes a-b as a+~b+1; carry_out is then NOT borrow
module pipelined_adder_sub
   import pipelined_adder_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SEG   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   localparam int unsigned NSTAGE = seg_count(WIDTH, SEG);

   if (WIDTH % SEG != 0 || WIDTH < SEG) begin : g_bad_width
      $error("pipelined_adder_sub: WIDTH must be a non-zero multiple of SEG");
   end

   // op_a[k] carries already-resolved sum bits below k*SEG and raw operand bits above.
   logic [WIDTH-1:0]  op_a  [NSTAGE];
   logic [WIDTH-1:0]  op_b  [NSTAGE];
   logic [WIDTH-1:0]  nxt_a [NSTAGE];
   logic [SEG-1:0]    seg_sum [NSTAGE];
   logic [NSTAGE-1:0] v_r, c_r, seg_cout, seg_cmsb;
   logic              advance;

   assign out_valid = v_r[NSTAGE-1];
   assign advance   = !out_valid || out_ready;
   assign in_ready  = advance;

   for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
      localparam logic [WIDTH-1:0] MASK = WIDTH'({SEG{1'b1}}) << (k*SEG);
      adder_segment #(.SEG(SEG)) u_seg (
         .a        (op_a[k][k*SEG +: SEG]),
         .b        (op_b[k][k*SEG +: SEG]),
         .cin      (c_r[k]),
         .sum      (seg_sum[k]),
         .cout     (seg_cout[k]),
         .c_msb_in (seg_cmsb[k])
      );
      assign nxt_a[k] = (op_a[k] & ~MASK) | (WIDTH'(seg_sum[k]) << (k*SEG));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_r <= '0;
         c_r <= '0;
         for (int i = 0; i < NSTAGE; i++) begin
            op_a[i] <= '0;
            op_b[i] <= '0;
         end
      end else if (advance) begin
         v_r[0]  <= in_valid;
         op_a[0] <= a;
         op_b[0] <= b ^ {WIDTH{sub}};
         c_r[0]  <= sub | carry_in;
         for (int i = 1; i < NSTAGE; i++) begin
            v_r[i]  <= v_r[i-1];
            op_a[i] <= nxt_a[i-1];
            op_b[i] <= op_b[i-1];
            c_r[i]  <= seg_cout[i-1];
         end
      end
   end

   // The last segment resolves combinationally off the frozen final registers,
   // so results stay stable under backpressure; gating keeps bubbles reading 0.
   assign sum       = out_valid ? nxt_a[NSTAGE-1] : '0;
   assign carry_out = out_valid & seg_cout[NSTAGE-1];
   assign overflow  = out_valid & (seg_cmsb[NSTAGE-1] ^ seg_cout[NSTAGE-1]);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb_pipelined_adder_sub: directed and streaming checks of pipelined_adder_sub (16-bit, 4-bit segments)
module tb_pipelined_adder_sub;

   localparam int W = 16;
   localparam int S = 4;
   localparam int N = W / S;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          in_valid = 1'b0, in_ready, carry_in = 1'b0, sub = 1'b0;
   logic          out_valid, out_ready = 1'b1, carry_out, overflow;
   logic [W-1:0]  a = '0, b = '0, sum;
   int            checks = 0, errors = 0, cyc = 0;
   logic [17:0]   got_q [$];
   int            got_cyc [$];

   typedef struct {
      logic [15:0] a, b;
      logic        cin, sub;
      logic [15:0] s;
      logic        co, ov;
   } vec_t;
   vec_t vecs [8];

   pipelined_adder_sub #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carry_in(carry_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back({overflow, carry_out, sum});
         got_cyc.push_back(cyc);
      end

   function automatic logic [17:0] model(input logic [15:0] x, y, input logic ci, sb);
      logic [15:0] yy;
      logic [16:0] r;
      logic        cm;
      yy = sb ? ~y : y;
      r  = {1'b0, x} + {1'b0, yy} + 17'(sb | ci);
      cm = x[15] ^ yy[15] ^ r[15];
      return {cm ^ r[16], r[16], r[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [15:0] x, y, input logic ci, sb);
      in_valid = 1'b1; a = x; b = y; carry_in = ci; sub = sb;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick;
         lat++;
      end
   endtask

   initial begin
      int          lat;
      logic [17:0] exp_q [$];
      logic [17:0] hold;
      logic [15:0] x, y;
      logic        ci, sb;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vecs[3] = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[5] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

      #2;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_sum", 32'(sum), 0);
      check("rst_carry_out", 32'(carry_out), 0);
      check("rst_overflow", 32'(overflow), 0);
      tick; tick;
      rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready), 1);

      foreach (vecs[i]) begin
         offer(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 1);
         tick;
         in_valid = 1'b0;
         wait_out(lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), N);
         check($sformatf("vec%0d_sum", i), 32'(sum), 32'(vecs[i].s));
         check($sformatf("vec%0d_carry_out", i), 32'(carry_out), 32'(vecs[i].co));
         check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
         tick;
      end

      got_q.delete(); got_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         x = 16'($urandom); y = 16'($urandom);
         ci = 1'($urandom); sb = 1'($urandom);
         exp_q.push_back(model(x, y, ci, sb));
         offer(x, y, ci, sb);
         tick;
      end
      in_valid = 1'b0;
      for (int t = 0; t < 30 && got_q.size() < 8; t++) tick;
      check("stream_count", 32'(got_q.size()), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++)
         check($sformatf("stream%0d_result", i), 32'(got_q[i]), 32'(exp_q[i]));
      if (got_q.size() == 8)
         check("stream_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 7);

      got_q.delete(); got_cyc.delete();
      out_ready = 1'b0;
      offer(16'h1234, 16'h0FFF, 1'b1, 1'b0); tick;
      offer(16'h0003, 16'h0005, 1'b0, 1'b1); tick;
      offer(16'h7FFF, 16'h0001, 1'b0, 1'b0); tick;
      in_valid = 1'b0;
      wait_out(lat);
      hold = {overflow, carry_out, sum};
      check("stall_head_result", 32'(hold), 32'h02234);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("stall%0d_in_ready", i), 32'(in_ready), 0);
         check($sformatf("stall%0d_out_valid", i), 32'(out_valid), 1);
         check($sformatf("stall%0d_stable", i), 32'({overflow, carry_out, sum}), 32'(hold));
         tick;
      end
      out_ready = 1'b1;
      for (int t = 0; t < 12; t++) tick;
      check("release_count", 32'(got_q.size()), 3);
      if (got_q.size() == 3) begin
         check("release0_result", 32'(got_q[0]), 32'h02234);
         check("release1_result", 32'(got_q[1]), 32'h0FFFE);
         check("release2_result", 32'(got_q[2]), 32'h28000);
      end

      offer(16'h8000, 16'h8001, 1'b0, 1'b0); tick;
      offer(16'h1111, 16'h2222, 1'b0, 1'b0); tick;
      offer(16'h4444, 16'h1111, 1'b0, 1'b1); tick;
      in_valid = 1'b0;
      tick;
      check("pre_reset_out_valid", 32'(out_valid), 1);
      check("pre_reset_carry_out", 32'(carry_out), 1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_reset_out_valid", 32'(out_valid), 0);
      check("mid_reset_sum", 32'(sum), 0);
      check("mid_reset_carry_out", 32'(carry_out), 0);
      check("mid_reset_overflow", 32'(overflow), 0);
      tick; tick;
      rst_n = 1'b1;
      got_q.delete(); got_cyc.delete();
      offer(16'h0003, 16'h0004, 1'b0, 1'b0);
      tick;
      in_valid = 1'b0;
      wait_out(lat);
      check("post_reset_latency", 32'(lat), N);
      check("post_reset_sum", 32'(sum), 32'h0007);
      for (int t = 0; t < 10; t++) tick;
      check("post_reset_no_stale", 32'(got_q.size()), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
